gemv_feeder: RTL
================

# gemv_feeder

Sequencer that drives one `gemv_subarray` (32x8 GeMV tile) from a beat stream and returns the finished 32-element result over a valid/ready handshake. Each job is a reduction over K = N x 8 inputs, delivered as N beats. Each beat carries an 8-element input slice and the matching 32x8 weight slice. The feeder issues `clear_acc` before each job and drives `enable` for one cycle per accepted beat. It counts the subarray's `valid_out` pulses to find the final accumulated vector, then latches it and holds it for downstream. It sits between the tile scheduler/DMA front end and the output writeback path.

## Interface
- INPUT_WIDTH, 8, input element width
- WEIGHT_WIDTH, 8, weight element width
- OUTPUT_WIDTH, 32, accumulator/result element width
- SUBARRAY_ROWS, 32, result vector length
- SUBARRAY_COLS, 8, input elements per beat
- MAX_BEATS, 64, max beats per job; counter width is clog2(MAX_BEATS+1)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of job
- in_vec  in  COLS x INPUT_WIDTH  input slice
- in_w  in  ROWS x COLS x WEIGHT_WIDTH  weight slice
- sa_enable  out  1  to subarray enable (registered)
- sa_clear_acc  out  1  to subarray clear_acc (registered)
- sa_input_vector  out  COLS x INPUT_WIDTH  registered in_vec
- sa_weight_matrix  out  ROWS x COLS x WEIGHT_WIDTH  registered in_w
- sa_output_vector  in  ROWS x OUTPUT_WIDTH  from subarray
- sa_valid_out  in  1  from subarray
- res_valid  out  1  result available
- res_ready  in  1  result consumed when res_valid && res_ready
- res_vector  out  ROWS x OUTPUT_WIDTH  latched result
- busy  out  1  state != IDLE
- err_overflow  out  1  sticky; a job reached MAX_BEATS without in_last

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, OUT.
- **IDLE**
  - in_ready=0.
  - When in_valid=1, go to CLEAR and zero beats_issued/valids_seen.
  - The beat stays pending; it is not consumed in IDLE.
- **CLEAR** (exactly 1 cycle)
  - Register sa_clear_acc=1 with sa_enable=0.
  - Go to STREAM.
- **STREAM**
  - in_ready=1.
  - On accept: next cycle sa_enable=1 and sa_input_vector/sa_weight_matrix hold that beat's data; beats_issued++.
  - No accept: sa_enable=0 (bubble). sa_* data holds its last value.
  - On accept with in_last=1, or when beats_issued reaches MAX_BEATS (set err_overflow), go to DRAIN.
- **Counting valid pulses**
  - In STREAM and DRAIN, every cycle with sa_valid_out=1 increments valids_seen.
  - The subarray emits exactly one valid_out pulse per enable cycle, 3 cycles after it, and sa_output_vector is valid in that same cycle.
- **DRAIN**
  - in_ready=0.
  - In the cycle where sa_valid_out=1 and valids_seen+1 == beats_issued, latch res_vector <= sa_output_vector and go to OUT.
- **OUT**
  - res_valid=1; res_vector stable; in_ready=0.
  - On res_ready=1, go to IDLE.
  - A new job's first beat is accepted no earlier than 2 cycles after the handshake (IDLE, then CLEAR).
- **Held data:** in_last, in_vec and in_w are sampled only on accept.
- **Arithmetic:** no arithmetic on data. Counters saturate at MAX_BEATS and never wrap.
- **sa_valid_out in IDLE/OUT** (stray pulse) is ignored and not counted.
- **Reset mid-job**
  - rst returns the FSM to IDLE; counters to 0; all outputs to 0.
  - rst does not clear err_overflow? No: err_overflow also clears on rst only.
  - The integrator resets the subarray in the same cycle.

## Timing
- **Reset values:** in_ready=0, sa_enable=0, sa_clear_acc=0, sa_input_vector=0, sa_weight_matrix=0, res_valid=0, res_vector=0, busy=0, err_overflow=0.
- **Start-up:** in_valid rise in IDLE (cycle t) → CLEAR at t+1 (sa_clear_acc visible t+1) → in_ready=1 at t+2.
- **Beat latency:** accept at cycle a → sa_enable at a+1 → subarray valid_out at a+4.
- **Job latency:** last beat accepted at cycle L with no bubbles → res_vector latched at the edge ending L+4 → res_valid=1 at L+5.
- **Single-beat job:** in_valid at t → res_valid at t+7.
- **Throughput:** back-to-back beats accepted 1 per cycle in STREAM.
- **Result hold:** res_valid stays high indefinitely under res_ready=0; res_vector does not change.

## Test plan
- **Single beat:** in_vec all 1, in_w all 2, in_last=1, paired with gemv_subarray → res_vector all rows = 16; res_valid 7 cycles after in_valid; sa_clear_acc pulsed exactly once, before the first sa_enable.
- **4-beat job:** beat k has in_vec all (k+1), in_w all 1, back-to-back → every row = 8*(1+2+3+4) = 80; exactly 4 sa_enable cycles.
- **Bubbles:** same 4-beat job with in_valid low 2 cycles between beats → result still 80; sa_enable low during the bubbles; completion delayed by 6 cycles.
- **Backpressure:** hold res_ready=0 for 10 cycles → res_valid and res_vector stable, in_ready=0; a second job starts only after the handshake, and its result is unaffected by the first (clear verified).
- **Overflow:** MAX_BEATS=4, send 6 beats with no in_last → only 4 accepted, err_overflow=1 (sticky), result = sum of the first 4 beats.
- **Reset mid-STREAM:** assert rst after 2 beats → next cycle all outputs are at their reset values and state is IDLE; a subsequent 1-beat job (all 1 x all 3) yields rows = 24.

Source files
------------

// File: rtl/gemv_feeder.sv
// Sequencer between the tile scheduler and one 32x8 GeMV subarray: clears the
// accumulator, streams beats into it, and holds the final vector for writeback.
module gemv_feeder #(
  parameter int INPUT_WIDTH   = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH  = 32,
  parameter int SUBARRAY_ROWS = 32,
  parameter int SUBARRAY_COLS = 8,
  parameter int MAX_BEATS     = 64
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic                                              in_last,
  input  logic [SUBARRAY_COLS*INPUT_WIDTH-1:0]              in_vec,
  input  logic [SUBARRAY_ROWS*SUBARRAY_COLS*WEIGHT_WIDTH-1:0] in_w,
  output logic                                              sa_enable,
  output logic                                              sa_clear_acc,
  output logic [SUBARRAY_COLS*INPUT_WIDTH-1:0]              sa_input_vector,
  output logic [SUBARRAY_ROWS*SUBARRAY_COLS*WEIGHT_WIDTH-1:0] sa_weight_matrix,
  input  logic [SUBARRAY_ROWS*OUTPUT_WIDTH-1:0]             sa_output_vector,
  input  logic                                              sa_valid_out,
  output logic                                              res_valid,
  input  logic                                              res_ready,
  output logic [SUBARRAY_ROWS*OUTPUT_WIDTH-1:0]             res_vector,
  output logic                                              busy,
  output logic                                              err_overflow
);

  localparam int VEC_W = SUBARRAY_COLS * INPUT_WIDTH;
  localparam int MAT_W = SUBARRAY_ROWS * SUBARRAY_COLS * WEIGHT_WIDTH;
  localparam int RES_W = SUBARRAY_ROWS * OUTPUT_WIDTH;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beats_issued, valids_seen;
  logic [CNT_W-1:0] beats_inc, valids_inc;
  logic             job_start, accept, beat_cap, end_of_stream, count_en, final_valid;

  logic             vld_p0;
  logic             clr_p0;
  logic [VEC_W-1:0] vec_p0;
  logic [MAT_W-1:0] w_p0;
  logic [RES_W-1:0] res_p1;

  assign beats_inc     = beats_issued + ONE_CNT;
  assign valids_inc    = valids_seen + ONE_CNT;
  assign job_start     = (state == IDLE) && in_valid;
  assign accept        = (state == STREAM) && in_valid;
  assign beat_cap      = (beats_inc >= MAX_CNT);
  assign end_of_stream = accept && (in_last || beat_cap);
  // Pulses outside STREAM/DRAIN are strays and must not disturb the count.
  assign count_en      = sa_valid_out && ((state == STREAM) || (state == DRAIN));
  assign final_valid   = (state == DRAIN) && sa_valid_out && (valids_inc == beats_issued);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = CLEAR;
      CLEAR:                      state_nxt = STREAM;
      STREAM:  if (end_of_stream) state_nxt = DRAIN;
      DRAIN:   if (final_valid)   state_nxt = OUT;
      OUT:     if (res_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Counters saturate at MAX_BEATS so a runaway source can never wrap them.
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_issued <= '0;
      valids_seen  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (job_start) begin
        beats_issued <= '0;
        valids_seen  <= '0;
      end else begin
        if (accept && (beats_issued != MAX_CNT)) beats_issued <= beats_inc;
        if (count_en && (valids_seen != MAX_CNT)) valids_seen <= valids_inc;
      end
      if (accept && !in_last && beat_cap) err_overflow <= 1'b1;
    end
  end

  // Stage p0: registered drive into the subarray, data captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      clr_p0 <= 1'b0;
      vec_p0 <= '0;
      w_p0   <= '0;
    end else begin
      vld_p0 <= accept;
      clr_p0 <= job_start;
      if (accept) begin
        vec_p0 <= in_vec;
        w_p0   <= in_w;
      end
    end
  end

  // Stage p1: final accumulated vector held until the downstream handshake.
  always_ff @(posedge clk) begin
    if (rst)              res_p1 <= '0;
    else if (final_valid) res_p1 <= sa_output_vector;
  end

  assign sa_enable        = vld_p0;
  assign sa_clear_acc     = clr_p0;
  assign sa_input_vector  = vec_p0;
  assign sa_weight_matrix = w_p0;
  assign res_vector       = res_p1;
  assign in_ready         = (state == STREAM);
  assign res_valid        = (state == OUT);
  assign busy             = (state != IDLE);

endmodule
